// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder.
//   chunk_of    : bits added per pipeline slice (WIDTH / STAGES)
//   geometry_ok : legal WIDTH/STAGES combination (used as an elaboration check)
//   ovf_calc    : two's-complement overflow from the operand and result MSBs
package pipelined_adder_pkg;

  function automatic int unsigned chunk_of(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  function automatic bit geometry_ok(input int unsigned width, input int unsigned stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Overflow iff both operands share a sign and the result's sign differs from it.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Stream interface of the pipelined adder.
//   Input stream : in_valid, in_ready, a, b, cin
//   Output stream: out_valid, out_ready, sum, cout, ovf
//   master : producer of operands / consumer of results (testbench or upstream logic)
//   slave  : the adder itself
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder_add_slice.sv
// Combinational CHUNK-bit adder slice: {co, s} = a + b + ci.
//   a, b : slice operands
//   ci   : carry into the slice LSB
//   s    : slice sum
//   co   : carry out of the slice MSB
module pipelined_adder_add_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with carry-in, carry-out and signed overflow.
// The carry chain is cut into STAGES registered slices of CHUNK bits each; every stage
// has its own valid bit and advances when it is empty or the stage below it can move,
// giving one op per cycle with lossless backpressure.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; discards every in-flight op
//   bus   : slave side of pipelined_adder_if (operand stream in, result stream out)
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);

  localparam int unsigned CHUNK = chunk_of(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES, STAGES <= WIDTH");
  end

  // Stage registers. a_q/b_q carry the operands down so later slices and the
  // final overflow check can see the bits not yet consumed.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              ovf_q;

  // Per-stage inputs (what stage k would capture) and slice results.
  logic [STAGES-1:0]            v_in;
  logic [STAGES-1:0]            c_in;
  logic [WIDTH-1:0]             a_in  [STAGES];
  logic [WIDTH-1:0]             b_in  [STAGES];
  logic [WIDTH-1:0]             s_in  [STAGES];
  logic [WIDTH-1:0]             sum_d [STAGES];
  logic [STAGES-1:0][CHUNK-1:0] slice_s;
  logic [STAGES-1:0]            slice_co;
  logic [STAGES:0]              ready;

  always_comb begin
    v_in[0] = bus.in_valid;
    c_in[0] = bus.cin;
    a_in[0] = bus.a;
    b_in[0] = bus.b;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = valid_q[k-1];
      c_in[k] = carry_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    pipelined_adder_add_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a  (a_in[k][k*CHUNK +: CHUNK]),
      .b  (b_in[k][k*CHUNK +: CHUNK]),
      .ci (c_in[k]),
      .s  (slice_s[k]),
      .co (slice_co[k])
    );
  end

  // Merge this stage's slice into the partial sum handed down from above.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = s_in[k];
      sum_d[k][k*CHUNK +: CHUNK] = slice_s[k];
    end
  end

  // ready_k = !valid_k | ready_{k+1}, unrolled from the output end as a running OR so
  // an empty stage anywhere below lets everything above it advance.
  always_comb begin
    logic r;
    r = bus.out_ready;
    ready[STAGES] = r;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r = r | ~valid_q[k];
      ready[k] = r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= v_in[k];
          // Data only moves with a real op so a bubble never disturbs held values.
          if (v_in[k]) begin
            a_q[k]     <= a_in[k];
            b_q[k]     <= b_in[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= slice_co[k];
          end
        end
      end
      if (ready[STAGES-1] && v_in[STAGES-1]) begin
        ovf_q <= ovf_calc(a_in[STAGES-1][WIDTH-1], b_in[STAGES-1][WIDTH-1],
                          sum_d[STAGES-1][WIDTH-1]);
      end
    end
  end

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(3))  bus3 ();
  pipelined_adder_if #(.WIDTH(1))  bus1 ();

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  pipelined_adder #(.WIDTH(3),  .STAGES(3)) dut3  (.clk(clk), .rst_n(rst_n), .bus(bus3));
  pipelined_adder #(.WIDTH(1),  .STAGES(1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Expected {sum, cout, ovf}, pushed on input transfer, popped on output transfer.
  logic [17:0] exp16_q[$];
  logic [4:0]  exp3_q[$];
  logic [2:0]  exp1_q[$];

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    logic [16:0] full;
    full = {1'b0, a} + {1'b0, b} + {16'b0, c};
    return {full[15:0], full[16], (a[15] == b[15]) && (full[15] != a[15])};
  endfunction

  function automatic logic [4:0] model3(input logic [2:0] a, input logic [2:0] b, input logic c);
    logic [3:0] full;
    full = {1'b0, a} + {1'b0, b} + {3'b0, c};
    return {full[2:0], full[3], (a[2] == b[2]) && (full[2] != a[2])};
  endfunction

  // Gate-level full adder; for one bit, overflow is a==b with sum differing from a.
  function automatic logic [2:0] fa_model(input logic a, input logic b, input logic c);
    logic s;
    s = a ^ b ^ c;
    return {s, (a & b) | (c & (a ^ b)), (a == b) && (s != a)};
  endfunction

  // One clock of the 16-bit stream: scoreboard push/pop at negedge, inputs change at +1.
  task automatic step();
    logic [17:0] exp;
    @(negedge clk);
    if (bus16.in_valid && bus16.in_ready)
      exp16_q.push_back(model16(bus16.a, bus16.b, bus16.cin));
    if (bus16.out_valid && bus16.out_ready) begin
      checks++;
      if (exp16_q.size() == 0) begin
        errors++;
        $display("FAIL sb16_extra: got %h with nothing expected",
                 {bus16.sum, bus16.cout, bus16.ovf});
      end else begin
        exp = exp16_q.pop_front();
        if ({bus16.sum, bus16.cout, bus16.ovf} !== exp) begin
          errors++;
          $display("FAIL sb16_result: got %h expected %h", {bus16.sum, bus16.cout, bus16.ovf},
                   exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
    bus3.in_valid  = 1'b0; bus3.a  = '0; bus3.b  = '0; bus3.cin  = 1'b0; bus3.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0; bus1.a  = '0; bus1.b  = '0; bus1.cin  = 1'b0; bus1.out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus16.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus16.out_valid);
    end
    checks++;
    if (bus16.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus16.in_ready);
    end
    checks++;
    if ({bus16.sum, bus16.cout, bus16.ovf} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0",
                         {bus16.sum, bus16.cout, bus16.ovf});
    end
    checks++;
    if ({bus3.out_valid, bus3.sum, bus3.cout, bus3.ovf} !== 6'h0) begin
      errors++; $display("FAIL reset_w3: got %h expected 0",
                         {bus3.out_valid, bus3.sum, bus3.cout, bus3.ovf});
    end
    checks++;
    if ({bus1.out_valid, bus1.in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_w1: got %b expected 01", {bus1.out_valid, bus1.in_ready});
    end
  endtask

  task automatic test_carry_wrap();
    int lat = 0;
    bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    while (!bus16.out_valid && lat < 10) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL latency: got %0d extra edges expected 3", lat);
    end
    checks++;
    if ({bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf} !== {1'b1, 16'h0000, 1'b1, 1'b0})
    begin
      errors++; $display("FAIL carry_wrap: got v=%b sum=%h cout=%b ovf=%b expected 1 0000 1 0",
                         bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
    end
    step();
    checks++;
    if (exp16_q.size() != 0 || bus16.out_valid !== 1'b0) begin
      errors++; $display("FAIL carry_wrap_drain: got q=%0d v=%b expected 0 0",
                         exp16_q.size(), bus16.out_valid);
    end
  endtask

  task automatic test_overflow();
    int lat = 0;
    bus16.a = 16'h7FFF; bus16.b = 16'h0001; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    step();
    bus16.a = 16'h8000; bus16.b = 16'h8000;
    step();
    bus16.in_valid = 1'b0;
    while (!bus16.out_valid && lat < 10) begin
      step();
      lat++;
    end
    checks++;
    if ({bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf} !== {1'b1, 16'h8000, 1'b0, 1'b1})
    begin
      errors++; $display("FAIL ovf_pos: got v=%b sum=%h cout=%b ovf=%b expected 1 8000 0 1",
                         bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
    end
    step();
    checks++;
    if ({bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf} !== {1'b1, 16'h0000, 1'b1, 1'b1})
    begin
      errors++; $display("FAIL ovf_neg: got v=%b sum=%h cout=%b ovf=%b expected 1 0000 1 1",
                         bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int last = -1;
    int n = 0;
    int stalls = 0;
    for (int i = 0; i < 20; i++) begin
      bus16.in_valid = (i < 8);
      bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
      if (i < 8 && !bus16.in_ready) stalls++;
      if (bus16.out_valid) begin
        if (first < 0) first = i;
        last = i;
        n++;
      end
      step();
    end
    bus16.in_valid = 1'b0;
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL b2b_in_ready: got %0d stalled cycles expected 0", stalls);
    end
    checks++;
    if (n != 8 || last - first != 7) begin
      errors++; $display("FAIL b2b_out_run: got %0d results over span %0d expected 8 over 7",
                         n, last - first);
    end
    checks++;
    if (exp16_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d pending expected 0", exp16_q.size());
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    int bad_hold = 0;
    int sz;
    bit have = 0;
    logic [17:0] held = '0;
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus16.in_valid = 1'b1;
      bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
      if (bus16.out_valid) begin
        if (!have) begin
          held = {bus16.sum, bus16.cout, bus16.ovf};
          have = 1;
        end else if ({bus16.sum, bus16.cout, bus16.ovf} !== held) begin
          bad_hold++;
        end
      end
      sz = exp16_q.size();
      step();
      if (exp16_q.size() > sz) acc++;
    end
    bus16.in_valid = 1'b0;
    checks++;
    if (acc != 4) begin
      errors++; $display("FAIL stall_accepted: got %0d expected 4", acc);
    end
    checks++;
    if ({bus16.in_ready, bus16.out_valid} !== 2'b01) begin
      errors++; $display("FAIL stall_handshake: got in_ready=%b out_valid=%b expected 0 1",
                         bus16.in_ready, bus16.out_valid);
    end
    checks++;
    if (!have || bad_hold != 0) begin
      errors++; $display("FAIL stall_hold: got seen=%0d changes=%0d expected 1 0", have,
                         bad_hold);
    end
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp16_q.size() > 0; i++) step();
    checks++;
    if (exp16_q.size() != 0 || bus16.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got q=%0d v=%b expected 0 0", exp16_q.size(),
                         bus16.out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    int emitted = 0;
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus16.in_valid = 1'b1;
      bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
      step();
    end
    bus16.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp16_q.delete();
    checks++;
    if ({bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf} !== 19'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0",
                         {bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf});
    end
    checks++;
    if (bus16.in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_in_ready: got %b expected 1", bus16.in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus16.out_valid) emitted++;
      step();
    end
    checks++;
    if (emitted != 0) begin
      errors++; $display("FAIL midreset_emitted: got %0d expected 0", emitted);
    end
  endtask

  task automatic test_random_stream();
    int sent = 0;
    int sz;
    for (int cyc = 0; cyc < 3000 && (sent < 200 || exp16_q.size() > 0); cyc++) begin
      bus16.in_valid  = (sent < 200) && ($urandom_range(3) != 0);
      bus16.out_ready = ($urandom_range(2) != 0);
      bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
      sz = exp16_q.size();
      step();
      if (exp16_q.size() > sz) sent++;
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    checks++;
    if (sent != 200 || exp16_q.size() != 0) begin
      errors++; $display("FAIL random_stream: got sent=%0d pending=%0d expected 200 0", sent,
                         exp16_q.size());
    end
  endtask

  task automatic test_exhaustive_small();
    int n3 = 0;
    int n1 = 0;
    int got3 = 0;
    int got1 = 0;
    logic [4:0] e3;
    logic [2:0] e1;
    for (int cyc = 0; cyc < 1500 && (got3 < 128 || got1 < 8); cyc++) begin
      bus3.in_valid  = (n3 < 128) && ($urandom_range(3) != 0);
      {bus3.a, bus3.b, bus3.cin} = 7'(n3);
      bus3.out_ready = ($urandom_range(3) != 0);
      bus1.in_valid  = (n1 < 8);
      {bus1.a, bus1.b, bus1.cin} = 3'(n1);
      bus1.out_ready = ($urandom_range(1) != 0);
      @(negedge clk);
      if (bus3.in_valid && bus3.in_ready) begin
        exp3_q.push_back(model3(bus3.a, bus3.b, bus3.cin));
        n3++;
      end
      if (bus3.out_valid && bus3.out_ready) begin
        checks++;
        got3++;
        e3 = (exp3_q.size() > 0) ? exp3_q.pop_front() : 5'bx;
        if ({bus3.sum, bus3.cout, bus3.ovf} !== e3) begin
          errors++; $display("FAIL w3_result: got %b expected %b",
                             {bus3.sum, bus3.cout, bus3.ovf}, e3);
        end
      end
      if (bus1.in_valid && bus1.in_ready) begin
        exp1_q.push_back(fa_model(bus1.a, bus1.b, bus1.cin));
        n1++;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        checks++;
        got1++;
        e1 = (exp1_q.size() > 0) ? exp1_q.pop_front() : 3'bx;
        if ({bus1.sum, bus1.cout, bus1.ovf} !== e1) begin
          errors++; $display("FAIL w1_result: got %b expected %b",
                             {bus1.sum, bus1.cout, bus1.ovf}, e1);
        end
      end
      @(posedge clk);
      #1;
    end
    bus3.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    checks++;
    if (got3 != 128 || exp3_q.size() != 0) begin
      errors++; $display("FAIL w3_count: got %0d results, %0d pending expected 128 0", got3,
                         exp3_q.size());
    end
    checks++;
    if (got1 != 8 || exp1_q.size() != 0) begin
      errors++; $display("FAIL w1_count: got %0d results, %0d pending expected 8 0", got1,
                         exp1_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random_stream();
    test_exhaustive_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
